// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester bus plus memory-side signals shared by the arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_data;
    logic                          mem_wren;
    logic [DATA_WIDTH-1:0]         mem_q;
    modport slave (
        input  req, we, addr, wdata, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_data, mem_wren
    );
    modport master (
        output req, we, addr, wdata, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous memory among NUM_REQ requesters.
// Each transaction runs IDLE (capture) -> ISSUE (grant, memory access) -> RESP (capture Q).
module mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t                state, state_n;
    logic [IW-1:0]         last_grant, last_n, owner, owner_n, win, cand;
    logic [NUM_REQ-1:0]    gnt_n, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata_n, mem_data_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic                  mem_wren_n;
    // Scan farthest-first so the requester nearest after last_grant overwrites win last.
    always_comb begin
        win  = last_grant;
        cand = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (bus.req[cand]) win = cand;
        end
    end
    always_comb begin
        state_n    = state;
        last_n     = last_grant;
        owner_n    = owner;
        gnt_n      = '0;
        rvalid_n   = '0;
        rdata_n    = bus.rdata;
        mem_addr_n = bus.mem_addr;
        mem_data_n = bus.mem_data;
        mem_wren_n = 1'b0;
        unique case (state)
            IDLE: if (|bus.req) begin
                state_n    = ISSUE;
                owner_n    = win;
                last_n     = win;
                gnt_n      = NUM_REQ'(1) << win;
                mem_addr_n = bus.addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data_n = bus.wdata[win*DATA_WIDTH +: DATA_WIDTH];
                mem_wren_n = bus.we[win];
            end
            ISSUE: state_n = RESP;
            RESP: begin
                state_n  = IDLE;
                rdata_n  = bus.mem_q;
                rvalid_n = NUM_REQ'(1) << owner;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= IW'(NUM_REQ - 1);
            owner        <= '0;
            bus.gnt      <= '0;
            bus.rvalid   <= '0;
            bus.rdata    <= '0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.mem_wren <= 1'b0;
        end else begin
            state        <= state_n;
            last_grant   <= last_n;
            owner        <= owner_n;
            bus.gnt      <= gnt_n;
            bus.rvalid   <= rvalid_n;
            bus.rdata    <= rdata_n;
            bus.mem_addr <= mem_addr_n;
            bus.mem_data <= mem_data_n;
            bus.mem_wren <= mem_wren_n;
        end
    end
endmodule
